// File: rtl/mainfsm_hs_if.sv
// Handshake and control bundle between the multicycle controller and the datapath.
// master = controller side, slave = datapath/decoder side.
interface mainfsm_hs_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             MulOp;
    logic             MemReady;
    logic             IRWrite;
    logic             NextPC;
    logic             Branch;
    logic             RegW;
    logic             MemW;
    logic             AdrSrc;
    logic             ALUOp;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             MemReq;
    logic             MulStart;
    logic             Fault;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;
    logic [CNT_W-1:0] StallCount;

    modport master (
        input  Op, Funct, MulOp, MemReady,
        output IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUOp,
        output ResultSrc, ALUSrcA, ALUSrcB, MemReq, MulStart, Fault,
        output State, InstrCount, StallCount
    );

    modport slave (
        output Op, Funct, MulOp, MemReady,
        input  IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUOp,
        input  ResultSrc, ALUSrcA, ALUSrcB, MemReq, MulStart, Fault,
        input  State, InstrCount, StallCount
    );
endinterface

// File: rtl/mainfsm_hs.sv
// Multicycle control FSM with memory handshake, timeout, multi-cycle MUL and sticky fault.
// Optional perf counters enabled by defining MAINFSM_HS_PERF_EN.
module mainfsm_hs #(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input logic       clk,
    input logic       reset,
    mainfsm_hs_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        EXECUTEM = 4'd10,
        MULWB    = 4'd11,
        FAULT    = 4'd15
    } state_t;

    localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);

    state_t        state, state_n;
    logic [WW-1:0] wcnt;
    logic [3:0]    mcnt;
    logic          mfirst;
    logic          memreq;
    logic          enter;
    logic          stall;
    logic          tmo;
    logic          unused_funct;

    assign unused_funct = ^bus.Funct[4:1];
    assign enter  = (state_n != state);
    assign memreq = (state == FETCH) || (state == MEMREAD) ||
                    (state == MEMWRITE);
    assign stall  = memreq && !bus.MemReady;
    assign tmo    = (MEM_TIMEOUT > 0) && stall && (wcnt == WMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            wcnt   <= '0;
            mcnt   <= '0;
            mfirst <= 1'b0;
        end else begin
            state  <= state_n;
            mfirst <= enter && (state_n == EXECUTEM);
            if (enter)
                wcnt <= '0;
            else if (stall && wcnt != WMAX)
                wcnt <= wcnt + WW'(1);
            if (enter && state_n == EXECUTEM)
                mcnt <= 4'(MUL_CYCLES - 1);
            else if (state == EXECUTEM && mcnt != 4'd0)
                mcnt <= mcnt - 4'd1;
        end
    end

    always_comb begin
        state_n       = state;
        bus.IRWrite   = 1'b0;
        bus.NextPC    = 1'b0;
        bus.Branch    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUOp     = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.MemReq    = 1'b0;
        bus.MulStart  = 1'b0;
        bus.Fault     = 1'b0;
        unique case (state)
            FETCH: begin
                bus.MemReq    = 1'b1;
                bus.ResultSrc = 2'b10;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                // Instruction latch is held off while reset is asserted.
                bus.IRWrite   = bus.MemReady & ~reset;
                bus.NextPC    = bus.MemReady & ~reset;
                if (bus.MemReady)
                    state_n = DECODE;
                else if (tmo)
                    state_n = FAULT;
            end
            DECODE: begin
                bus.ResultSrc = 2'b10;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                unique case (1'b1)
                    bus.Op == 2'b00 && bus.Funct[5]:
                        state_n = EXECUTEI;
                    bus.Op == 2'b00 && !bus.Funct[5] && bus.MulOp:
                        state_n = EXECUTEM;
                    bus.Op == 2'b00 && !bus.Funct[5] && !bus.MulOp:
                        state_n = EXECUTER;
                    bus.Op == 2'b01: state_n = MEMADR;
                    bus.Op == 2'b10: state_n = BRANCH;
                    bus.Op == 2'b11: state_n = FAULT;
                    default:         state_n = FAULT;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcB = 2'b01;
                state_n = bus.Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.MemReq  = 1'b1;
                bus.AdrSrc  = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.MemReady)
                    state_n = MEMWB;
                else if (tmo)
                    state_n = FAULT;
            end
            MEMWRITE: begin
                bus.MemReq  = 1'b1;
                bus.MemW    = 1'b1;
                bus.AdrSrc  = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.MemReady)
                    state_n = FETCH;
                else if (tmo)
                    state_n = FAULT;
            end
            MEMWB: begin
                bus.RegW      = 1'b1;
                bus.AdrSrc    = 1'b1;
                bus.ResultSrc = 2'b01;
                bus.ALUSrcB   = 2'b01;
                state_n = FETCH;
            end
            EXECUTER: begin
                bus.ALUOp = 1'b1;
                state_n = ALUWB;
            end
            EXECUTEI: begin
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 1'b1;
                state_n = ALUWB;
            end
            EXECUTEM: begin
                bus.MulStart = mfirst;
                if (mcnt == 4'd0)
                    state_n = MULWB;
            end
            ALUWB: begin
                bus.RegW    = 1'b1;
                bus.ALUSrcB = 2'b01;
                state_n = FETCH;
            end
            MULWB: begin
                bus.RegW      = 1'b1;
                bus.ResultSrc = 2'b11;
                state_n = FETCH;
            end
            BRANCH: begin
                bus.Branch    = 1'b1;
                bus.ResultSrc = 2'b10;
                bus.ALUSrcA   = 2'b10;
                bus.ALUSrcB   = 2'b01;
                state_n = FETCH;
            end
            FAULT: begin
                bus.Fault = 1'b1;
            end
            default: state_n = FAULT;
        endcase
    end

    assign bus.State = state;

`ifdef MAINFSM_HS_PERF_EN
    logic [CNT_W-1:0] icnt, scnt;

    // Retirement = any return to FETCH; only completing states lead there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt <= '0;
            scnt <= '0;
        end else begin
            if (state_n == FETCH && state != FETCH)
                icnt <= icnt + CNT_W'(1);
            if (stall && scnt != '1)
                scnt <= scnt + CNT_W'(1);
        end
    end

    assign bus.InstrCount = icnt;
    assign bus.StallCount = scnt;
`else
    assign bus.InstrCount = {CNT_W{1'b0}};
    assign bus.StallCount = {CNT_W{1'b0}};
`endif
endmodule
